div_scheduler: RTL and testbench

//   Shares one iterative unsigned divider between two requesters (port 0, port 1).

---
 rtl/div_scheduler_if.sv | 60 ++++++
 rtl/div_scheduler.sv | 147 ++++++++++++++
 tb/tb_div_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/div_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : div_scheduler_if
// Purpose  : Bundles the two requester channels and the response channel of
//            the shared divider scheduler.
// Ports    : req0_valid/req0_ready/req0_a/req0_b  - requester 0 channel
//            req1_valid/req1_ready/req1_a/req1_b  - requester 1 channel
//            rsp_valid/rsp_ready/rsp_id           - response handshake + owner
//            rsp_quotient/rsp_remainder           - A / B and A % B
//            rsp_div0                             - divide-by-zero flag, present
//                                                   only with DIV_SCHED_DIV0_EN
// Modports : master - requesters and result consumer
//            slave  - divider scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface div_scheduler_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
`ifdef DIV_SCHED_DIV0_EN
  logic             rsp_div0;
`endif

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder
`ifdef DIV_SCHED_DIV0_EN
    , input rsp_div0
`endif
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_quotient, rsp_remainder
`ifdef DIV_SCHED_DIV0_EN
    , output rsp_div0
`endif
  );
endinterface
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : div_scheduler
// Purpose  : Shares one iterative restoring shift-subtract unsigned divider
//            between two requesters with round-robin arbitration. One
//            quotient bit is produced per cycle, MSB first; the result is
//            returned tagged with the winning requester's ID.
// Ports    : clk    - clock, rising edge
//            rst    - synchronous active-high reset
//            bus    - div_scheduler_if.slave (request/response channels)
//            o_busy - high whenever the scheduler is not idle
// Options  : DIV_SCHED_DIV0_EN - adds bus.rsp_div0, set for a B==0 result
// Revision : 1.0 - initial release
// ============================================================================
module div_scheduler #(
  parameter int WIDTH = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  div_scheduler_if.slave bus,
  output logic           o_busy
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam int c_RW    = WIDTH + 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic               r_last_grant;
  logic               r_id;
  logic [WIDTH-1:0]   r_b;
  // Holds the dividend while dividing; quotient bits shift in from the LSB
  // as dividend bits shift out of the MSB, so it ends holding the quotient.
  logic [WIDTH-1:0]   r_quo;
  logic [c_RW-1:0]    r_rem;
  logic [c_CNT_W-1:0] r_cnt;
`ifdef DIV_SCHED_DIV0_EN
  logic               r_div0;
`endif

  logic               w_idle;
  logic               w_grant0;
  logic               w_grant1;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [c_RW:0]      w_trial;
  logic               w_qbit;
  logic [c_RW-1:0]    w_rem_next;

  // Arbitration: a lone requester wins; on a tie the port that did not win
  // last time wins. Nothing is granted outside IDLE or while in reset.
  always_comb begin
    w_idle   = (r_state == c_IDLE);
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_idle && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || r_last_grant)) begin
        w_grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_sel_a = w_grant1 ? bus.req1_a : bus.req0_a;
  assign w_sel_b = w_grant1 ? bus.req1_b : bus.req0_b;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    w_trial    = {r_rem, r_quo[WIDTH-1]};
    w_qbit     = (w_trial >= {2'b00, r_b});
    w_rem_next = w_qbit ? c_RW'(w_trial - {2'b00, r_b}) : c_RW'(w_trial);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_b          <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
`ifdef DIV_SCHED_DIV0_EN
      r_div0       <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_b          <= w_sel_b;
            r_rem        <= '0;
            r_cnt        <= c_CNT_W'(WIDTH - 1);
            if (w_sel_b == '0) begin
              // Divide by zero skips the iterations and reports Q=0, R=0.
              r_quo   <= '0;
              r_state <= c_DONE;
`ifdef DIV_SCHED_DIV0_EN
              r_div0  <= 1'b1;
`endif
            end else begin
              r_quo   <= w_sel_a;
              r_state <= c_CALC;
`ifdef DIV_SCHED_DIV0_EN
              r_div0  <= 1'b0;
`endif
            end
          end
        end
        c_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_DONE: begin
          if (bus.rsp_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.req0_ready    = w_grant0;
  assign bus.req1_ready    = w_grant1;
  assign bus.rsp_valid     = (r_state == c_DONE);
  assign bus.rsp_id        = r_id;
  assign bus.rsp_quotient  = r_quo;
  assign bus.rsp_remainder = r_rem[WIDTH-1:0];
`ifdef DIV_SCHED_DIV0_EN
  assign bus.rsp_div0      = r_div0;
`endif
  assign o_busy            = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_scheduler
// Purpose  : Self-checking bench for div_scheduler: directed scenarios plus
//            randomized traffic, compared against a behavioural model of
//            arbitration, latency and exact unsigned division.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_scheduler;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   model_last;

  always #5 clk = ~clk;

  div_scheduler_if #(.WIDTH(WIDTH)) bus ();

  div_scheduler #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .o_busy (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: present requests, check arbitration, wait for
  // the response with a bounded wait, check result, optionally stall the
  // consumer for `hold` cycles, then accept.
  task automatic txn(input bit v0, input bit v1,
                     input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                     input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                     input int hold, input string tag);
    int w;
    int lat;
    int k;
    int ea;
    int eb;
    int eq;
    int er;
    logic [31:0] snap;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
    if (v0 && v1) w = (model_last == 0) ? 1 : 0;
    else          w = v0 ? 0 : 1;
    check({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(w == 0));
    check({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(w == 1));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    ea = (w == 1) ? int'(a1) : int'(a0);
    eb = (w == 1) ? int'(b1) : int'(b0);
    eq = (eb == 0) ? 0 : ea / eb;
    er = (eb == 0) ? 0 : ea % eb;
    lat = (eb == 0) ? 1 : WIDTH + 1;
    step();
    model_last = w;
    // Winner withdraws and scribbles its operands; loser keeps holding.
    if (w == 0) begin
      bus.req0_valid = 1'b0; bus.req0_a = WIDTH'($urandom); bus.req0_b = WIDTH'($urandom);
    end else begin
      bus.req1_valid = 1'b0; bus.req1_a = WIDTH'($urandom); bus.req1_b = WIDTH'($urandom);
    end
    k = 1;
    while (k <= 30) begin
      if (bus.rsp_valid === 1'b1) break;
      check({tag, "_busy_calc"}, {29'd0, busy, bus.req0_ready, bus.req1_ready}, 32'd4);
      step();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(w));
    check({tag, "_quot"}, 32'(bus.rsp_quotient), 32'(eq));
    check({tag, "_rem"}, 32'(bus.rsp_remainder), 32'(er));
`ifdef DIV_SCHED_DIV0_EN
    check({tag, "_div0"}, 32'(bus.rsp_div0), 32'(eb == 0));
`endif
    snap = {19'd0, bus.rsp_valid, bus.rsp_id, busy, bus.rsp_quotient, bus.rsp_remainder, bus.req0_ready, bus.req1_ready};
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold"},
            {19'd0, bus.rsp_valid, bus.rsp_id, busy, bus.rsp_quotient, bus.rsp_remainder, bus.req0_ready, bus.req1_ready},
            snap);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check({tag, "_noacc_done"}, {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_back_idle"}, {30'd0, bus.rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] a0, b0, a1, b1;
    bit v0, v1;

    // Reset with requests pending: no grants, all outputs cleared.
    rst = 1'b1;
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd5; bus.req1_b = 4'd1;
    step();
    step();
    check("rst_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    check("rst_outs", {20'd0, bus.rsp_valid, bus.rsp_id, busy, 1'b0, bus.rsp_quotient, bus.rsp_remainder}, 32'd0);
`ifdef DIV_SCHED_DIV0_EN
    check("rst_div0", 32'(bus.rsp_div0), 32'd0);
`endif
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    model_last = 1;
    step();

    // Basic operation and latency.
    txn(1, 0, 4'd13, 4'd4, 4'd0, 4'd0, 0, "t1");
    // Simultaneous requests, held loser, round-robin repeat.
    txn(1, 1, 4'd15, 4'd2, 4'd9, 4'd3, 0, "t2a");
    txn(0, 1, 4'd0, 4'd0, 4'd9, 4'd3, 0, "t2b");
    txn(1, 1, 4'd15, 4'd2, 4'd9, 4'd3, 0, "t2c");
    txn(0, 1, 4'd0, 4'd0, 4'd9, 4'd3, 0, "t2d");
    // Divide by zero.
    txn(0, 1, 4'd0, 4'd0, 4'd7, 4'd0, 0, "t3");
    // Consumer stall of 10 cycles.
    txn(1, 0, 4'd11, 4'd3, 4'd0, 4'd0, 10, "t4");

    // Reset in the second CALC cycle of a port-0 operation.
    bus.req0_valid = 1'b1; bus.req0_a = 4'd14; bus.req0_b = 4'd3;
    #1;
    check("t5_rdy0", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    step();
    check("t5_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_cleared", {20'd0, bus.rsp_valid, bus.rsp_id, busy, 1'b0, bus.rsp_quotient, bus.rsp_remainder}, 32'd0);
    model_last = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    // Port 0 wins this tie only if last_grant returned to 1.
    txn(1, 1, 4'd5, 4'd1, 4'd6, 4'd2, 0, "t5a");
    txn(0, 1, 4'd0, 4'd0, 4'd6, 4'd2, 0, "t5b");

    // Boundary operands.
    txn(1, 0, 4'd3, 4'd9, 4'd0, 4'd0, 0, "t6a");
    txn(0, 1, 4'd0, 4'd0, 4'd15, 4'd1, 1, "t6b");
    txn(1, 0, 4'd15, 4'd15, 4'd0, 4'd0, 0, "t6c");

    // Randomized traffic; a port still holding its request keeps it.
    for (int n = 0; n < 60; n++) begin
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      a0 = bus.req0_a; b0 = bus.req0_b;
      a1 = bus.req1_a; b1 = bus.req1_b;
      if (!v0) begin
        v0 = 1'($urandom);
        a0 = WIDTH'($urandom);
        b0 = WIDTH'($urandom);
      end
      if (!v1) begin
        v1 = 1'($urandom);
        a1 = WIDTH'($urandom);
        b1 = WIDTH'($urandom);
      end
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, v1, a0, b0, a1, b1, int'($urandom_range(0, 2)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
